// File: rtl/tilt_pkg.sv
// rtl/tilt_pkg.sv - shared widths, encodings and period helper for the tilt step controller
package tilt_pkg;

  localparam int SAMPLE_W  = 10;
  localparam int AVG_DEPTH = 4;
  localparam int AVG_LOG2  = 2;
  localparam int SUM_W     = SAMPLE_W + AVG_LOG2;
  localparam int PERIOD_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2
  } step_state_t;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // Step period in ticks: shrinks one tick per count of tilt beyond the dead-zone, floored at period_min.
  function automatic logic [PERIOD_W-1:0] calc_period(
    input logic [SAMPLE_W-1:0] mag,
    input int                  deadzone,
    input int                  period_max,
    input int                  period_min
  );
    int p;
    p = period_max - (int'(mag) - deadzone);
    if (p < period_min) p = period_min;
    return PERIOD_W'(p);
  endfunction

endpackage

// File: rtl/axis_step_engine.sv
// rtl/axis_step_engine.sv - per-axis tick-driven step pulse generator
module axis_step_engine
  import tilt_pkg::*;
#(
  parameter int PULSE_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                enable,
  input  logic                active,
  input  dir_t                sign,
  input  logic [PERIOD_W-1:0] period,
  output logic                pos_out,
  output logic                neg_out
);

  step_state_t         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  dir_t                dir_q, dir_d;

  // State, tick counter and latched direction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_POS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next state: wait out the period, then hold the latched direction for PULSE_TICKS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && active) begin
          state_d = ST_WAIT;
          cnt_d   = period;
        end
      end
      ST_WAIT: begin
        if (!enable || !active) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (cnt_q == PERIOD_W'(1)) begin
            state_d = ST_PULSE;
            dir_d   = sign;
            cnt_d   = PERIOD_W'(PULSE_TICKS);
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
        end
      end
      ST_PULSE: begin
        // A started pulse runs to completion unless the whole block is disabled.
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (cnt_q == PERIOD_W'(1)) begin
            if (active) begin
              state_d = ST_WAIT;
              cnt_d   = period - PERIOD_W'(PULSE_TICKS);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pos_out = enable && (state_q == ST_PULSE) && (dir_q == DIR_POS);
  assign neg_out = enable && (state_q == ST_PULSE) && (dir_q == DIR_NEG);

endmodule

// File: rtl/tilt_step_ctrl.sv
// rtl/tilt_step_ctrl.sv - accelerometer tilt to maze step strobes
module tilt_step_ctrl
  import tilt_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int DEADZONE    = 16,
  parameter int PERIOD_MAX  = 250,
  parameter int PERIOD_MIN  = 40,
  parameter int PULSE_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                data_valid,
  input  logic [SAMPLE_W-1:0] xAxis,
  input  logic [SAMPLE_W-1:0] yAxis,
  output logic                up,
  output logic                down,
  output logic                left,
  output logic                right,
  output logic                tilt_active
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0]              tick_cnt;
  logic                       tick;
  logic signed [SAMPLE_W-1:0] win_x [AVG_DEPTH];
  logic signed [SAMPLE_W-1:0] win_y [AVG_DEPTH];
  logic signed [SUM_W-1:0]    sum_x, sum_y;
  logic signed [SAMPLE_W-1:0] avg_x, avg_y;
  logic [SAMPLE_W-1:0]        mag_x, mag_y;
  logic                       active_x, active_y;
  dir_t                       sign_x, sign_y;
  logic [PERIOD_W-1:0]        period_x, period_y;
  logic                       act_q;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Free-running tick divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Sample windows: newest at index 0, oldest falls off the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        win_x[i] <= '0;
        win_y[i] <= '0;
      end
    end else if (data_valid) begin
      win_x[0] <= xAxis;
      win_y[0] <= yAxis;
      for (int i = 1; i < AVG_DEPTH; i++) begin
        win_x[i] <= win_x[i-1];
        win_y[i] <= win_y[i-1];
      end
    end
  end

  // Sign-extended window sums.
  always_comb begin
    sum_x = '0;
    sum_y = '0;
    for (int i = 0; i < AVG_DEPTH; i++) begin
      sum_x = sum_x + {{AVG_LOG2{win_x[i][SAMPLE_W-1]}}, win_x[i]};
      sum_y = sum_y + {{AVG_LOG2{win_y[i][SAMPLE_W-1]}}, win_y[i]};
    end
  end

  assign avg_x = SAMPLE_W'(sum_x >>> AVG_LOG2);
  assign avg_y = SAMPLE_W'(sum_y >>> AVG_LOG2);

  // Unsigned magnitude; -512 wraps onto 512 which is exact in 10 unsigned bits.
  assign mag_x = avg_x[SAMPLE_W-1] ? SAMPLE_W'(-avg_x) : SAMPLE_W'(avg_x);
  assign mag_y = avg_y[SAMPLE_W-1] ? SAMPLE_W'(-avg_y) : SAMPLE_W'(avg_y);

  assign active_x = (mag_x > SAMPLE_W'(DEADZONE));
  assign active_y = (mag_y > SAMPLE_W'(DEADZONE));

  assign sign_x = avg_x[SAMPLE_W-1] ? DIR_NEG : DIR_POS;
  assign sign_y = avg_y[SAMPLE_W-1] ? DIR_NEG : DIR_POS;

  assign period_x = calc_period(mag_x, DEADZONE, PERIOD_MAX, PERIOD_MIN);
  assign period_y = calc_period(mag_y, DEADZONE, PERIOD_MAX, PERIOD_MIN);

  // Registered "either axis is tilted" flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q <= 1'b0;
    end else begin
      act_q <= active_x | active_y;
    end
  end

  assign tilt_active = act_q & enable;

  axis_step_engine #(
    .PULSE_TICKS(PULSE_TICKS)
  ) u_eng_x (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .enable (enable),
    .active (active_x),
    .sign   (sign_x),
    .period (period_x),
    .pos_out(right),
    .neg_out(left)
  );

  axis_step_engine #(
    .PULSE_TICKS(PULSE_TICKS)
  ) u_eng_y (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .enable (enable),
    .active (active_y),
    .sign   (sign_y),
    .period (period_y),
    .pos_out(down),
    .neg_out(up)
  );

endmodule

// File: tb/tb_tilt_step_ctrl.sv
// tb/tb_tilt_step_ctrl.sv - randomized and directed bench for tilt_step_ctrl
module tb_tilt_step_ctrl;

  localparam int TD   = 8;
  localparam int DZ   = 16;
  localparam int PMAX = 250;
  localparam int PMIN = 40;
  localparam int PT   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       data_valid = 1'b0;
  logic [9:0] xAxis = '0;
  logic [9:0] yAxis = '0;
  logic       up, down, left, right, tilt_active;

  tilt_step_ctrl #(
    .TICK_DIV   (TD),
    .DEADZONE   (DZ),
    .PERIOD_MAX (PMAX),
    .PERIOD_MIN (PMIN),
    .PULSE_TICKS(PT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_valid (data_valid),
    .xAxis      (xAxis),
    .yAxis      (yAxis),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .tilt_active(tilt_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: sample windows, tick phase, absolute tick count, and per-axis deadlines
  int mwx [4];
  int mwy [4];
  int mtick;
  int mT;
  int mmode [2];
  int mdl   [2];
  int mdir  [2];
  bit mact_q;

  bit cur_en;
  int cur_x, cur_y;
  int cyc;
  bit prev_right;
  int rise_q [$];
  int fall_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int avg_of(input int w [4]);
    int s;
    s = w[0] + w[1] + w[2] + w[3];
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic int clampv(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic logic [4:0] exp_outs(input bit en);
    logic u, d, l, r;
    u = en && mmode[1] == 2 && mdir[1] < 0;
    d = en && mmode[1] == 2 && mdir[1] > 0;
    l = en && mmode[0] == 2 && mdir[0] < 0;
    r = en && mmode[0] == 2 && mdir[0] > 0;
    return {u, d, l, r, en && mact_q};
  endfunction

  function automatic logic lvl(input int sel);
    case (sel)
      0:       return up;
      1:       return down;
      2:       return left;
      default: return right;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mwx[i] = 0;
      mwy[i] = 0;
    end
    mtick = 0;
    mT = 0;
    mact_q = 1'b0;
    for (int a = 0; a < 2; a++) begin
      mmode[a] = 0;
      mdl[a] = 0;
      mdir[a] = 1;
    end
  endtask

  task automatic model_step(input bit en, input bit dv, input int xv, input int yv);
    bit tk;
    bit any;
    int av, mag, per;
    bit act;
    tk = (mtick == TD - 1);
    if (tk) mT++;
    any = 1'b0;
    for (int a = 0; a < 2; a++) begin
      av  = (a == 0) ? avg_of(mwx) : avg_of(mwy);
      mag = (av < 0) ? -av : av;
      act = (mag > DZ);
      per = PMAX - (mag - DZ);
      if (per < PMIN) per = PMIN;
      any = any | act;
      case (mmode[a])
        0: if (en && act) begin
          mmode[a] = 1;
          mdl[a] = mT + per;
        end
        1: if (!en || !act) begin
          mmode[a] = 0;
        end else if (tk && mT == mdl[a]) begin
          mmode[a] = 2;
          mdir[a] = (av < 0) ? -1 : 1;
          mdl[a] = mT + PT;
        end
        default: if (!en) begin
          mmode[a] = 0;
        end else if (tk && mT == mdl[a]) begin
          if (act) begin
            mmode[a] = 1;
            mdl[a] = mT + per - PT;
          end else begin
            mmode[a] = 0;
          end
        end
      endcase
    end
    mact_q = any;
    if (dv) begin
      for (int i = 3; i > 0; i--) begin
        mwx[i] = mwx[i-1];
        mwy[i] = mwy[i-1];
      end
      mwx[0] = xv;
      mwy[0] = yv;
    end
    mtick = tk ? 0 : mtick + 1;
  endtask

  // called at a negedge; drives inputs, checks outputs, advances one clock
  task automatic run_cycle(input bit dv);
    enable = cur_en;
    data_valid = dv;
    xAxis = 10'(cur_x);
    yAxis = 10'(cur_y);
    #1;
    check("outs", {up, down, left, right, tilt_active}, exp_outs(cur_en));
    if (right && !prev_right) rise_q.push_back(cyc);
    if (!right && prev_right) fall_q.push_back(cyc);
    prev_right = right;
    cyc++;
    @(posedge clk);
    model_step(cur_en, dv, cur_x, cur_y);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int dv_every);
    for (int i = 0; i < n; i++) run_cycle(dv_every > 0 && (i % dv_every) == 0);
  endtask

  task automatic run_until(input string tag, input int sel, input bit val, input int limit, output int used);
    used = 0;
    while (lvl(sel) !== val && used < limit) begin
      run_cycle(1'b0);
      used++;
    end
    check(tag, lvl(sel), val);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check(tag, {up, down, left, right, tilt_active}, 5'd0);
    model_reset();
    @(negedge clk);
    enable = 1'b1;
    #1;
    check({tag, "_hold"}, {up, down, left, right, tilt_active}, 5'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int pick_base();
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 32)) - 16;
      1:       return int'($urandom_range(17, 120));
      2:       return -int'($urandom_range(17, 120));
      3:       return int'($urandom_range(0, 1023)) - 512;
      default: return ($urandom_range(0, 1) == 1) ? -512 : 511;
    endcase
  endfunction

  initial begin
    int used, used_b, c_en;
    cyc = 0;
    prev_right = 1'b0;
    cur_en = 1'b0;
    cur_x = 0;
    cur_y = 0;
    model_reset();
    @(negedge clk);
    do_reset("reset");

    // dead-zone: avg exactly 16 on both axes never moves
    cur_en = 1'b1; cur_x = 16; cur_y = -16;
    run(8, 1);
    run(2000, 0);
    check("dz_tilt_active", tilt_active, 0);
    check("dz_dirs", {up, down, left, right}, 4'd0);

    // small tilt: period 246 ticks, pulse 20 ticks
    cur_en = 1'b0; cur_x = 20; cur_y = 0;
    run(4, 1);
    run(2, 0);
    cur_en = 1'b1;
    rise_q.delete();
    fall_q.delete();
    run(3 * 246 * TD + 100, 0);
    check("t3_rise_count", (rise_q.size() >= 2) ? 1 : 0, 1);
    if (rise_q.size() >= 2) check("t3_period", rise_q[1] - rise_q[0], 246 * TD);
    if (rise_q.size() >= 1 && fall_q.size() >= 1) check("t3_width", fall_q[0] - rise_q[0], 20 * TD);

    // reset while right is pulsing
    run_until("t1_wait_right", 3, 1'b1, 250 * TD, used);
    do_reset("t1_reset_mid_pulse");
    cur_en = 1'b1;
    run(500, 0);
    check("t1_quiet_after", {up, down, left, right}, 4'd0);

    // full tilt up: period clamps at 40
    cur_en = 1'b0; cur_x = 0; cur_y = -400;
    run(4, 1);
    run(2, 0);
    cur_en = 1'b1;
    run_until("t4_first_up", 0, 1'b1, 41 * TD + 10, used);
    run_until("t4_up_fall", 0, 1'b0, 25 * TD, used);
    check("t4_width", used, 20 * TD);
    run_until("t4_up_rise", 0, 1'b1, 25 * TD, used_b);
    check("t4_gap", used_b, 20 * TD);
    check("t4_tilt_active", tilt_active, 1);

    // sign flip during WAIT, then during PULSE
    cur_en = 1'b0; cur_x = 100; cur_y = 0;
    run(4, 1);
    run(2, 0);
    cur_en = 1'b1;
    run_until("t5_right", 3, 1'b1, 170 * TD, used);
    run_until("t5_right_fall", 3, 1'b0, 25 * TD, used);
    run(10, 0);
    cur_x = -100;
    run(4, 1);
    run_until("t5_left", 2, 1'b1, 400 * TD, used);
    cur_x = 100;
    run(4, 1);
    check("t5_left_holds", left, 1);
    run(30 * TD, 0);

    // enable drop during a down pulse, then a full period after re-enable
    cur_en = 1'b0; cur_x = 0; cur_y = 200;
    run(4, 1);
    run(2, 0);
    cur_en = 1'b1;
    run_until("t6_down", 1, 1'b1, 67 * TD + 10, used);
    run(3, 0);
    cur_en = 1'b0;
    run_cycle(1'b0);
    check("t6_drop", down, 0);
    run(5, 0);
    cur_en = 1'b1;
    c_en = cyc;
    run_until("t6_redown", 1, 1'b1, 67 * TD + 10, used);
    check("t6_period_lo", (cyc - c_en > 65 * TD) ? 1 : 0, 1);
    check("t6_period_hi", (cyc - c_en <= 66 * TD) ? 1 : 0, 1);

    // randomized segments against the model
    for (int s = 0; s < 24; s++) begin
      int len, dve, bx, by;
      if ($urandom_range(0, 7) == 0) do_reset("rand_reset");
      cur_en = ($urandom_range(0, 9) != 0);
      bx  = pick_base();
      by  = pick_base();
      len = int'($urandom_range(300, 1500));
      dve = int'($urandom_range(1, 20));
      for (int c = 0; c < len; c++) begin
        bit dv;
        dv = ($urandom_range(0, dve - 1) == 0);
        if (dv) begin
          cur_x = clampv(bx + int'($urandom_range(0, 8)) - 4);
          cur_y = clampv(by + int'($urandom_range(0, 8)) - 4);
        end
        if ($urandom_range(0, 399) == 0) cur_en = !cur_en;
        run_cycle(dv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tilt_step_ctrl.md
Name: tilt_step_ctrl

Overview:
- Converts raw PmodACL tilt samples (xAxis/yAxis) into up/down/left/right step strobes for maze_and_ball.
- Drop-in replacement for the debounced button levels.
- Per axis: 4-sample moving average, dead-zone, then a tick-based step engine.
- Step rate grows with tilt magnitude. Each step is stretched long enough for the slow maze clock to sample it.

Parameters:
- TICK_DIV, 100000: clk cycles per tick (1 ms at 100 MHz).
- DEADZONE, 16: |avg| at or below this value produces no motion.
- PERIOD_MAX, 250: step period in ticks at just-over-deadzone tilt.
- PERIOD_MIN, 40: shortest step period in ticks; must be greater than PULSE_TICKS.
- PULSE_TICKS, 20: ticks a direction output stays high per step.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  0 forces idle and clears engines
- data_valid  in  1  one-clk strobe: xAxis/yAxis hold a new sample
- xAxis  in  10  signed two's-complement X tilt
- yAxis  in  10  signed two's-complement Y tilt
- up  out  1  step-up level
- down  out  1  step-down level
- left  out  1  step-left level
- right  out  1  step-right level
- tilt_active  out  1  either axis outside the dead-zone

Behaviour:
- Reset (rst=0, async): all outputs 0, averaging windows 0, tick counter 0, both engines IDLE.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 for the one cycle where the count wraps.
- Averaging, per axis:
  - On data_valid, shift the sample into a 4-entry window (oldest dropped).
  - sum = 12-bit signed sum; avg = sum >>> 2 (arithmetic).
  - The window starts at zeros, so the first 3 samples are attenuated.
  - avg registers 1 cycle after data_valid.
- Magnitude: mag = |avg|, 10 bits; -512 maps to 512.
- Period: period = max(PERIOD_MIN, PERIOD_MAX - (mag - DEADZONE)) when mag > DEADZONE.
- Sign mapping: X>0 gives right, X<0 gives left; Y>0 gives down, Y<0 gives up.
- Engine FSM per axis (axis_step_engine), states IDLE, WAIT, PULSE:
  - IDLE: dir outputs 0. When mag > DEADZONE and enable=1, load cnt=period and go to WAIT.
  - WAIT: decrement cnt on each tick. At tick with cnt==1:
    - latch direction from the current avg sign;
    - load cnt=PULSE_TICKS;
    - go to PULSE.
    - If mag <= DEADZONE at any cycle, go to IDLE.
  - PULSE: the latched direction output is 1. Decrement on tick. At tick with cnt==1:
    - output goes 0;
    - if still out of the dead-zone, load cnt=period-PULSE_TICKS and go to WAIT;
    - else go to IDLE.
    - A pulse in progress always completes even if tilt drops; this avoids runt pulses to the slow domain.
- Opposite directions (up/down, left/right) are never both 1.
- enable=0: both engines go to IDLE next cycle and all direction outputs drop to 0 immediately (combinationally gated). Averaging keeps running.
- The period is re-evaluated at each reload, not mid-count.
- tilt_active = registered OR of both axes' (mag > DEADZONE), gated by enable.
- data_valid arriving on a tick cycle: both events are processed in the same cycle, with no loss.
- All outputs are registered except the enable gating.

Decomposition:
- Package tilt_pkg:
  - localparams for average depth (4) and its log2 (2);
  - state encoding IDLE/WAIT/PULSE (2-bit);
  - direction encoding (NEG/POS).
- Sub-module axis_step_engine:
  - one per axis;
  - inputs clk, rst, tick, enable, active, sign, period;
  - outputs pos_out, neg_out.
- Averaging and period math stay in the top.

Test Plan:
1. Reset mid-PULSE: assert rst=0 with right=1 -> all outputs 0 in the same cycle; after release, no pulse until tilt is re-evaluated.
2. Dead-zone: 8 samples x=+16, y=-16 -> avg=16 each; no outputs ever; tilt_active=0.
3. Small tilt: 4 samples x=+20 (period=246 ticks), enable=1 -> right rises 246 ticks after WAIT entry, stays high 20 ticks, repeats every 246 ticks; left stays 0.
4. Full tilt: y=-400 (avg -400, period clamps to 40) -> up high 20 ticks every 40 ticks; down stays 0; tilt_active=1.
5. Sign flip: x=+100 held, then x=-100 fed during WAIT -> the next pulse is on left, not right; a flip during PULSE completes the right pulse first.
6. Enable drop: enable=0 during PULSE on down -> down=0 the same cycle, engine goes IDLE. Re-enable with y=+200 -> first down pulse occurs after a full period (66 ticks).
